// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter that shares one registered ALU between NREQ requesters.
// Each accepted operation runs IDLE -> ISSUE -> EXEC -> RESP, one at a time.
// When ALU_ARB_DIVZERO_TRAP_EN is defined, op 3 with B == 0 is not issued; the
// arbiter goes straight to RESP with resp_err = 1 and resp_data = 0.
module alu_issue_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned DW   = 72
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [DW*NREQ-1:0]   req_a,
  input  logic [DW*NREQ-1:0]   req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [DW-1:0]        resp_data,
  output logic                 resp_err,
  output logic [3:0]           alu_op,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  input  logic [DW-1:0]        alu_c,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  scan_id;
  logic [3:0]      win_op;
  logic [DW-1:0]   win_a;
  logic [DW-1:0]   win_b;
  logic            trap;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_id = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!win_found && req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
    win_op = req_op[4*32'(win_id) +: 4];
    win_a  = req_a[DW*32'(win_id) +: DW];
    win_b  = req_b[DW*32'(win_id) +: DW];
  end

  // Next-state, grant and datapath load decisions.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cur_id_d     = cur_id_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    req_ready    = '0;
    trap         = 1'b0;
`ifdef ALU_ARB_DIVZERO_TRAP_EN
    trap = (win_op == 4'd3) && (win_b == '0);
`endif
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          req_ready = NREQ'(1) << win_id;
          rr_ptr_d  = IDW'((32'(win_id) + 1) % NREQ);
          cur_id_d  = win_id;
          if (trap) begin
            // Divide by zero answered locally; ALU inputs left untouched.
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
            resp_id_d    = win_id;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end else begin
            alu_op_d = win_op;
            alu_a_d  = win_a;
            alu_b_d  = win_b;
            state_d  = StIssue;
          end
        end
      end
      StIssue: state_d = StExec;
      StExec: begin
        resp_data_d  = alu_c;
        resp_id_d    = cur_id_q;
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      cur_id_q     <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cur_id_q     <= cur_id_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != StIdle);

endmodule
